// File: rtl/ras_ckpt.sv
// rtl/ras_ckpt.sv - return address stack with pointer/count checkpoint and restore
module ras_ckpt #(
   parameter int RAS_DEPTH        = 8,
   parameter int RAS_TARGET_WIDTH = 12,
   parameter int RAS_INDEX_WIDTH  = $clog2(RAS_DEPTH),
   parameter int OVERFLOW_WRAP    = 1
) (
   input  logic                        CLK,
   input  logic                        RST,
   input  logic                        push_valid,
   input  logic [RAS_TARGET_WIDTH-1:0] push_target,
   input  logic                        pop_valid,
   input  logic                        restore_valid,
   input  logic [RAS_INDEX_WIDTH-1:0]  restore_ptr,
   input  logic [RAS_INDEX_WIDTH:0]    restore_count,
   output logic                        top_valid,
   output logic [RAS_TARGET_WIDTH-1:0] top_target,
   output logic [RAS_INDEX_WIDTH-1:0]  ckpt_ptr,
   output logic [RAS_INDEX_WIDTH:0]    ckpt_count,
   output logic                        overflow_event,
   output logic                        underflow_event
);

   localparam int CW = RAS_INDEX_WIDTH + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(RAS_DEPTH);

   logic [RAS_TARGET_WIDTH-1:0] mem_q [RAS_DEPTH];
   logic [RAS_INDEX_WIDTH-1:0]  ptr_q, ptr_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        ovf_q, ovf_d;
   logic                        unf_q, unf_d;
   logic                        wr_en;
   logic [RAS_INDEX_WIDTH-1:0]  wr_idx;
   logic [RAS_INDEX_WIDTH-1:0]  tos;
   logic                        full;
   logic                        empty;

   // Top of stack sits one below the next-free pointer, wrapping in index width.
   assign tos   = ptr_q - 1'b1;
   assign full  = (count_q == DEPTH_C);
   assign empty = (count_q == '0);

   // Next-state decode in priority order: restore, push&pop, push, pop.
   always_comb begin
      ptr_d   = ptr_q;
      count_d = count_q;
      wr_en   = 1'b0;
      wr_idx  = ptr_q;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      if (restore_valid) begin
         ptr_d   = restore_ptr;
         count_d = (restore_count > DEPTH_C) ? DEPTH_C : restore_count;
      end else if (push_valid && pop_valid && !empty) begin
         // Return+call in one fetch block: overwrite the current top in place.
         wr_en  = 1'b1;
         wr_idx = tos;
      end else if (push_valid) begin
         if (!full) begin
            wr_en   = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            count_d = count_q + 1'b1;
         end else begin
            ovf_d = 1'b1;
            if (OVERFLOW_WRAP != 0) begin
               wr_en = 1'b1;
               ptr_d = ptr_q + 1'b1;
            end
         end
      end else if (pop_valid) begin
         if (!empty) begin
            ptr_d   = ptr_q - 1'b1;
            count_d = count_q - 1'b1;
         end else begin
            unf_d = 1'b1;
         end
      end
   end

   // Pointer, count and event pulse registers.
   always_ff @(posedge CLK) begin
      if (RST) begin
         ptr_q   <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         ptr_q   <= ptr_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

   // Target storage; popped entries are left intact so a restore can recover them.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < RAS_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (wr_en) begin
         mem_q[wr_idx] <= push_target;
      end
   end

   assign top_valid       = !empty;
   assign top_target      = mem_q[tos];
   assign ckpt_ptr        = ptr_q;
   assign ckpt_count      = count_q;
   assign overflow_event  = ovf_q;
   assign underflow_event = unf_q;

endmodule
